// File: rtl/adder_pipe_arbiter_pkg.sv
// Shared constants and types for the pipelined-adder arbiter slice.
package adder_pipe_arbiter_pkg;

  // Operand width, fixed to the shared adder.
  localparam int W         = 16;
  // Cycles from operand issue to adder_sum/adder_cout valid.
  localparam int LAT       = 5;
  // Widest tag needed for the largest supported requester count (8).
  localparam int TAG_MAX_W = 3;

  // Requester-index width: at least one bit even for tiny configurations.
  function automatic int tag_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

  // One granted operation as presented to the adder, plus its origin.
  typedef struct packed {
    logic [W-1:0]         a;
    logic [W-1:0]         b;
    logic                 cin;
    logic [TAG_MAX_W-1:0] tag;
  } add_req_t;

endpackage

// File: rtl/adder_pipe_arbiter_rr_arbiter.sv
// NREQ-way round-robin arbiter: combinational one-hot grant, registered
// pointer that moves just past the winner whenever a grant is issued.
module rr_arbiter
  import adder_pipe_arbiter_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int TAG_W = tag_width(NREQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [NREQ-1:0]  req_valid_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [TAG_W-1:0] gnt_idx_o,
  output logic             gnt_any_o
);

  logic [TAG_W-1:0] ptr_q;
  logic [TAG_W-1:0] ptr_d;

  // Scan requesters starting at the pointer, wrapping modulo NREQ; first valid wins.
  always_comb begin
    int   idx;
    logic found;
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end else begin
        idx = idx;
      end
      if (en_i && !found && req_valid_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = TAG_W'(idx);
      end else begin
        found = found;
      end
    end
    gnt_any_o = found;
  end

  // Next pointer: one past the winner on a grant, otherwise unchanged.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any_o) begin
      if (gnt_idx_o == TAG_W'(NREQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = gnt_idx_o + TAG_W'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register, returns to requester 0 on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/adder_pipe_arbiter.sv
// Shares one pipelined 16-bit adder between NREQ requesters. A round-robin
// arbiter picks one operation per cycle; a valid/tag shift pipe running in
// step with the adder steers each result back to its originator. The adder
// samples a/b at the issue edge but reads cin one cycle later, so cin is
// delayed by a register here.
module adder_pipe_arbiter
  import adder_pipe_arbiter_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [W*NREQ-1:0] req_a,
  input  logic [W*NREQ-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  output logic [W-1:0]      adder_a,
  output logic [W-1:0]      adder_b,
  output logic              adder_cin,
  input  logic [W-1:0]      adder_sum,
  input  logic              adder_cout,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_sum,
  output logic              rsp_cout,
  output logic [2:0]        inflight,
  output logic [15:0]       issue_count
);

  localparam int TAG_W = tag_width(NREQ);

  logic [NREQ-1:0]  gnt;
  logic [TAG_W-1:0] gnt_idx;
  logic             issue;
  add_req_t         sel;
  logic             retire;

  // Valid/tag pipe: entry LAT-1 lines up with the adder output.
  logic [LAT-1:0]                vld_q;
  logic [LAT-1:0][TAG_MAX_W-1:0] tag_q;
  logic                          cin_q;
  logic [2:0]                    inflight_q;
  logic [2:0]                    inflight_d;
  logic [15:0]                   issue_count_q;

  // No grants while reset is asserted, so nothing issues in that cycle.
  rr_arbiter #(
    .NREQ  (NREQ),
    .TAG_W (TAG_W)
  ) u_rr (
    .clk         (clk),
    .reset       (reset),
    .en_i        (~reset),
    .req_valid_i (req_valid),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_any_o   (issue)
  );

  // AND-OR mux of the granted requester's operands; all zero when idle.
  always_comb begin
    sel     = '0;
    sel.tag = TAG_MAX_W'(gnt_idx);
    for (int i = 0; i < NREQ; i++) begin
      sel.a   = sel.a | (req_a[W*i +: W] & {W{gnt[i]}});
      sel.b   = sel.b | (req_b[W*i +: W] & {W{gnt[i]}});
      sel.cin = sel.cin | (req_cin[i] & gnt[i]);
    end
  end

  assign req_ready = gnt;
  assign adder_a   = sel.a;
  assign adder_b   = sel.b;
  assign adder_cin = cin_q;
  assign retire    = vld_q[LAT-1];

  // Occupancy next state: an issue and a retirement in one cycle cancel out.
  always_comb begin
    inflight_d = inflight_q;
    case ({issue, retire})
      2'b10:   inflight_d = inflight_q + 3'd1;
      2'b01:   inflight_d = inflight_q - 3'd1;
      default: inflight_d = inflight_q;
    endcase
  end

  // Pipe shift, cin delay and counters; reset drops every in-flight op.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q         <= '0;
      tag_q         <= '0;
      cin_q         <= 1'b0;
      inflight_q    <= 3'd0;
      issue_count_q <= 16'd0;
    end else begin
      vld_q         <= {vld_q[LAT-2:0], issue};
      tag_q         <= {tag_q[LAT-2:0], sel.tag};
      cin_q         <= issue & sel.cin;
      inflight_q    <= inflight_d;
      issue_count_q <= issue_count_q + {15'd0, issue};
    end
  end

  // Decode the tag leaving the pipe into a one-hot response strobe.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid[i] = ~reset & retire & (tag_q[LAT-1] == TAG_MAX_W'(i));
    end
  end

  assign rsp_sum     = adder_sum;
  assign rsp_cout    = adder_cout;
  assign inflight    = inflight_q;
  assign issue_count = issue_count_q;

endmodule

// File: tb/tb_adder_pipe_arbiter.sv
// Bench for adder_pipe_arbiter: behavioural adder attached to the DUT,
// queue-based reference of grants/results, directed scenarios plus random.
module tb_adder_pipe_arbiter;

  localparam int NREQ = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ-1:0]  req_ready;
  logic [16*NREQ-1:0] req_a;
  logic [16*NREQ-1:0] req_b;
  logic [NREQ-1:0]  req_cin;
  logic [15:0]      adder_a;
  logic [15:0]      adder_b;
  logic             adder_cin;
  logic [15:0]      adder_sum;
  logic             adder_cout;
  logic [NREQ-1:0]  rsp_valid;
  logic [15:0]      rsp_sum;
  logic             rsp_cout;
  logic [2:0]       inflight;
  logic [15:0]      issue_count;

  always #5 clk = ~clk;

  adder_pipe_arbiter #(.NREQ(NREQ)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_cin     (req_cin),
    .adder_a     (adder_a),
    .adder_b     (adder_b),
    .adder_cin   (adder_cin),
    .adder_sum   (adder_sum),
    .adder_cout  (adder_cout),
    .rsp_valid   (rsp_valid),
    .rsp_sum     (rsp_sum),
    .rsp_cout    (rsp_cout),
    .inflight    (inflight),
    .issue_count (issue_count)
  );

  // Behavioural shared adder: a/b captured at issue edge, cin used the next
  // cycle, result visible 5 cycles after issue.
  logic [15:0] ad_ra, ad_rb;
  logic [16:0] ad_p0, ad_p1, ad_p2, ad_p3;
  always @(posedge clk) begin
    if (reset) begin
      ad_ra <= '0; ad_rb <= '0;
      ad_p0 <= '0; ad_p1 <= '0; ad_p2 <= '0; ad_p3 <= '0;
    end else begin
      ad_ra <= adder_a;
      ad_rb <= adder_b;
      ad_p0 <= {1'b0, ad_ra} + {1'b0, ad_rb} + {16'd0, adder_cin};
      ad_p1 <= ad_p0;
      ad_p2 <= ad_p1;
      ad_p3 <= ad_p2;
    end
  end
  assign adder_sum  = ad_p3[15:0];
  assign adder_cout = ad_p3[16];

  // Reference model state.
  typedef struct {
    int          due;
    int          tag;
    logic [15:0] sum;
    logic        cout;
  } exp_t;
  exp_t        q[$];
  int          m_now = 0;
  int          m_ptr = 0;
  logic        m_cin_prev = 1'b0;
  logic [15:0] m_count = 16'd0;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h (model cycle %0d)", nm, act, exp, m_now);
    end
  endtask

  // Compare all DUT outputs with the model for the current cycle, then
  // advance the model across the coming clock edge.
  task automatic model_step();
    int          g;
    int          idx;
    logic [NREQ-1:0] exp_rdy;
    logic [15:0] ea, eb;
    logic        ec;
    logic [NREQ-1:0] exp_rv;
    logic [16:0] tot;
    exp_t        e;
    while (q.size() > 0 && q[0].due < m_now) void'(q.pop_front());
    g = -1;
    if (!reset) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    exp_rdy = '0; ea = '0; eb = '0; ec = 1'b0;
    if (g >= 0) begin
      exp_rdy[g] = 1'b1;
      ea = req_a[16*g +: 16];
      eb = req_b[16*g +: 16];
      ec = req_cin[g];
    end
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("adder_a", 32'(adder_a), 32'(ea));
    chk("adder_b", 32'(adder_b), 32'(eb));
    chk("adder_cin", 32'(adder_cin), 32'(m_cin_prev));
    chk("inflight", 32'(inflight), 32'(q.size()));
    chk("issue_count", 32'(issue_count), 32'(m_count));
    exp_rv = '0;
    if (!reset && q.size() > 0 && q[0].due == m_now) exp_rv[q[0].tag] = 1'b1;
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    if (exp_rv != '0) begin
      chk("rsp_sum", 32'(rsp_sum), 32'(q[0].sum));
      chk("rsp_cout", 32'(rsp_cout), 32'(q[0].cout));
    end
    if (reset) begin
      q.delete();
      m_ptr = 0;
      m_cin_prev = 1'b0;
      m_count = 16'd0;
    end else if (g >= 0) begin
      tot = {1'b0, ea} + {1'b0, eb} + {16'd0, ec};
      e.due = m_now + 5; e.tag = g; e.sum = tot[15:0]; e.cout = tot[16];
      q.push_back(e);
      m_ptr = (g + 1) % NREQ;
      m_cin_prev = ec;
      m_count = m_count + 16'd1;
    end else begin
      m_cin_prev = 1'b0;
    end
    m_now++;
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [15:0] a0, input logic [15:0] b0,
                       input logic [15:0] a1, input logic [15:0] b1, input logic [1:0] c);
    req_valid = v;
    req_a = {a1, a0};
    req_b = {b1, b0};
    req_cin = c;
  endtask

  initial begin
    int peak;
    logic [15:0] ca, cb;
    reset = 1'b1;
    drive(2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    req_valid = 2'b11;
    tick();
    chk("reset_ready", 32'(req_ready), 32'h0);
    chk("reset_inflight", 32'(inflight), 32'h0);
    chk("reset_count", 32'(issue_count), 32'h0);
    chk("reset_cin", 32'(adder_cin), 32'h0);
    chk("reset_rsp", 32'(rsp_valid), 32'h0);
    adv();
    reset = 1'b0;

    // Single op on requester 0.
    for (int c = 0; c < 9; c++) begin
      if (c == 0) drive(2'b01, 16'h0001, 16'hFFFF, 16'h0, 16'h0, 2'b00);
      else        drive(2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 2'b00);
      tick();
      if (c >= 1) chk("single_inflight", 32'(inflight), (c <= 5) ? 32'h1 : 32'h0);
      if (c == 5) begin
        chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("single_sum", 32'(rsp_sum), 32'h0000);
        chk("single_cout", 32'(rsp_cout), 32'h1);
      end
      adv();
    end

    // Carry-in alignment on requester 1.
    for (int c = 0; c < 8; c++) begin
      if (c == 0) drive(2'b10, 16'h0, 16'h0, 16'h7FFF, 16'h0000, 2'b10);
      else        drive(2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 2'b00);
      tick();
      chk("cin_align", 32'(adder_cin), (c == 1) ? 32'h1 : 32'h0);
      if (c == 5) begin
        chk("cin_rsp_valid", 32'(rsp_valid), 32'h2);
        chk("cin_sum", 32'(rsp_sum), 32'h8000);
        chk("cin_cout", 32'(rsp_cout), 32'h0);
      end
      adv();
    end

    // Contention: both requesters every cycle for 8 cycles.
    peak = 0;
    for (int c = 0; c < 15; c++) begin
      ca = 16'h1000 + 16'(c);
      cb = 16'h2000 + 16'(c);
      if (c < 8) drive(2'b11, ca, 16'h0100, cb, 16'h0200, 2'b00);
      else       drive(2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 2'b00);
      tick();
      if (int'(inflight) > peak) peak = int'(inflight);
      if (c < 8) chk("cont_grant", 32'(req_ready), (c % 2 == 0) ? 32'h1 : 32'h2);
      if (c >= 5 && c <= 12) begin
        chk("cont_rsp_valid", 32'(rsp_valid), ((c - 5) % 2 == 0) ? 32'h1 : 32'h2);
        chk("cont_sum", 32'(rsp_sum),
            ((c - 5) % 2 == 0) ? 32'(16'h1100 + 16'(c - 5)) : 32'(16'h2200 + 16'(c - 5)));
      end
      adv();
    end
    chk("cont_peak", 32'(peak), 32'd5);

    // Bubbles: requester 0 issues in cycles 0 and 3 only.
    for (int c = 0; c < 10; c++) begin
      if (c == 0 || c == 3) drive(2'b01, 16'h00AA, 16'h0055, 16'h0, 16'h0, 2'b00);
      else                  drive(2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 2'b00);
      tick();
      if (c >= 1) chk("bubble_rsp", 32'(rsp_valid), (c == 5 || c == 8) ? 32'h1 : 32'h0);
      if (c == 5 || c == 8) chk("bubble_sum", 32'(rsp_sum), 32'h00FF);
      adv();
    end

    // Reset while three ops are in flight.
    for (int c = 0; c < 12; c++) begin
      reset = (c == 3);
      if (c < 3)       drive(2'b01, 16'h0100 + 16'(c), 16'h0001, 16'h0, 16'h0, 2'b00);
      else if (c == 3) drive(2'b11, 16'h0F0F, 16'h0F0F, 16'h0F0F, 16'h0F0F, 2'b11);
      else if (c == 4) drive(2'b11, 16'h1234, 16'h1111, 16'h4321, 16'h2222, 2'b01);
      else             drive(2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 2'b00);
      tick();
      if (c == 3) chk("rst_mid_ready", 32'(req_ready), 32'h0);
      if (c == 4) begin
        chk("rst_mid_inflight", 32'(inflight), 32'h0);
        chk("rst_mid_count", 32'(issue_count), 32'h0);
        chk("rst_mid_ptr", 32'(req_ready), 32'h1);
      end
      if (c >= 3) chk("rst_mid_rsp", 32'(rsp_valid), (c == 9) ? 32'h1 : 32'h0);
      if (c == 9) chk("rst_mid_sum", 32'(rsp_sum), 32'h2346);
      adv();
    end
    reset = 1'b0;

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      drive(2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 2'($urandom));
      tick();
      adv();
    end
    reset = 1'b0;

    // Issue counter wrap: 65537 issues after a reset.
    reset = 1'b1;
    drive(2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 2'b00);
    tick();
    adv();
    reset = 1'b0;
    for (int c = 0; c < 65537; c++) begin
      drive(2'b11, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 2'($urandom));
      tick();
      adv();
    end
    drive(2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 2'b00);
    tick();
    chk("wrap_count", 32'(issue_count), 32'h0001);
    adv();
    for (int c = 0; c < 6; c++) begin
      tick();
      adv();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
